// File: rtl/square_wave_meter.sv
// Square-wave meter: measures the high and low phase lengths of a clk-synchronous
// signal in base ticks and reports each complete, unsaturated period once.
module square_wave_meter #(
  parameter int BASE_CYCLES = 10,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             signal_in,
  output logic [CNT_W-1:0] on_ticks,
  output logic [CNT_W-1:0] off_ticks,
  output logic             valid,
  output logic             timeout
);

  localparam int               PW         = (BASE_CYCLES > 1) ? $clog2(BASE_CYCLES) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(BASE_CYCLES - 1);
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } state_t;

  state_t           state_q;
  logic             sig_q;
  logic             primed_q;
  logic [PW-1:0]    presc_q;
  logic [PW-1:0]    presc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] high_cap_q;
  logic             have_high_q;

  logic             edge_s;
  logic             rise_s;
  logic             fall_s;
  logic             tick_s;
  logic             cnt_sat_s;

  // Edge detection and next values of the prescaler and phase tick counter
  always_comb begin
    edge_s    = primed_q && (signal_in != sig_q);
    rise_s    = edge_s && signal_in;
    fall_s    = edge_s && !signal_in;
    tick_s    = (presc_q == PRESC_LAST);
    cnt_sat_s = (cnt_q == CNT_MAX);

    // Loading 1 on the edge makes a phase of H cycles read floor(H/BASE_CYCLES)
    if (edge_s) begin
      presc_d = PRESC_ONE;
    end else if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PRESC_ONE;
    end

    if (edge_s) begin
      cnt_d = '0;
    end else if (tick_s && !cnt_sat_s) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Input history, prescaler, tick counter and the registered timeout level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_q    <= 1'b0;
      primed_q <= 1'b0;
      presc_q  <= '0;
      cnt_q    <= '0;
      timeout  <= 1'b0;
    end else begin
      sig_q    <= signal_in;
      primed_q <= 1'b1;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      timeout  <= (cnt_d == CNT_MAX);
    end
  end

  // Phase FSM: captures the high length at a fall, publishes the period at the next rise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= WAIT_EDGE;
      have_high_q <= 1'b0;
      high_cap_q  <= '0;
      on_ticks    <= '0;
      off_ticks   <= '0;
      valid       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        WAIT_EDGE: begin
          if (rise_s) begin
            state_q <= HIGH;
          end else if (fall_s) begin
            state_q <= LOW;
          end
        end
        HIGH: begin
          if (fall_s) begin
            state_q <= LOW;
            if (!cnt_sat_s) begin
              high_cap_q  <= cnt_q;
              have_high_q <= 1'b1;
            end else begin
              have_high_q <= 1'b0;
            end
          end
        end
        LOW: begin
          if (rise_s) begin
            state_q     <= HIGH;
            have_high_q <= 1'b0;
            if (have_high_q && !cnt_sat_s) begin
              on_ticks  <= high_cap_q;
              off_ticks <= cnt_q;
              valid     <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= WAIT_EDGE;
          have_high_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square_wave_meter.sv
// Self-checking bench for square_wave_meter: directed phase sequences plus random
// phases, checked every cycle against a phase-length arithmetic reference model.
module tb_square_wave_meter;

  localparam int B    = 10;
  localparam int CW   = 8;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          signal_in;
  logic [CW-1:0] on_ticks;
  logic [CW-1:0] off_ticks;
  logic          valid;
  logic          timeout;

  int vectors;
  int miscompares;

  // reference model state: cycle index, start of current phase, edges since reset
  int            cyc;
  int            m_ref;
  int            m_edges;
  int            m_high_ticks;
  logic          m_primed;
  logic          m_prev;
  logic [CW-1:0] exp_on;
  logic [CW-1:0] exp_off;
  logic          exp_valid;
  logic          exp_timeout;

  square_wave_meter #(.BASE_CYCLES(B), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .signal_in (signal_in),
    .on_ticks  (on_ticks),
    .off_ticks (off_ticks),
    .valid     (valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_outputs();
    vectors++;
    assert (valid === exp_valid) else begin
      miscompares++;
      $error("FAIL valid cyc %0d: observed %0b expected %0b", cyc, valid, exp_valid);
    end
    assert (on_ticks === exp_on) else begin
      miscompares++;
      $error("FAIL on_ticks cyc %0d: observed %0d expected %0d", cyc, on_ticks, exp_on);
    end
    assert (off_ticks === exp_off) else begin
      miscompares++;
      $error("FAIL off_ticks cyc %0d: observed %0d expected %0d", cyc, off_ticks, exp_off);
    end
    assert (timeout === exp_timeout) else begin
      miscompares++;
      $error("FAIL timeout cyc %0d: observed %0b expected %0b", cyc, timeout, exp_timeout);
    end
  endtask

  task automatic check_meas(input string tag, input int on_e, input int off_e);
    vectors++;
    assert (on_ticks === CW'(on_e) && off_ticks === CW'(off_e)) else begin
      miscompares++;
      $error("FAIL %s: observed %0d/%0d expected %0d/%0d", tag, on_ticks, off_ticks, on_e, off_e);
    end
  endtask

  task automatic step(input logic lvl);
    int ticks;
    signal_in = lvl;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    if (m_primed && (lvl != m_prev)) begin
      m_edges++;
      ticks = (cyc - m_ref) / B;
      if (lvl) begin
        if (m_edges >= 3 && m_high_ticks < MAXV && ticks < MAXV) begin
          exp_valid = 1'b1;
          exp_on    = CW'(m_high_ticks);
          exp_off   = CW'(ticks);
        end
      end else begin
        m_high_ticks = ticks;
      end
      m_ref = cyc;
    end
    exp_timeout = (((cyc - m_ref + 1) / B) >= MAXV);
    m_prev   = lvl;
    m_primed = 1'b1;
    cyc++;
    check_outputs();
  endtask

  task automatic phase(input logic lvl, input int n);
    repeat (n) step(lvl);
  endtask

  task automatic do_reset(input logic lvl, input int hold);
    reset = 1'b0;
    #1;
    exp_on      = '0;
    exp_off     = '0;
    exp_valid   = 1'b0;
    exp_timeout = 1'b0;
    check_outputs();
    repeat (hold) @(posedge clk);
    #1;
    signal_in    = lvl;
    reset        = 1'b1;
    m_primed     = 1'b0;
    m_prev       = 1'b0;
    m_edges      = 0;
    m_high_ticks = 0;
    m_ref        = cyc;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    reset       = 1'b1;
    signal_in   = 1'b0;
    #2;

    // basic 30/20 stream after a quiet low stretch
    do_reset(1'b0, 3);
    phase(1'b0, 50);
    repeat (4) begin
      phase(1'b1, 30);
      phase(1'b0, 20);
    end
    phase(1'b1, 5);
    check_meas("stream_30_20", 3, 2);
    phase(1'b0, 20);

    // truncation boundaries of the high phase
    phase(1'b1, 5);  phase(1'b0, 10);
    phase(1'b1, 10); phase(1'b0, 10);
    phase(1'b1, 19); phase(1'b0, 10);
    phase(1'b1, 20); phase(1'b0, 10);
    phase(1'b1, 30);
    check_meas("high_20_low_10", 2, 1);

    // saturating low phase, then recovery
    phase(1'b0, 3000);
    phase(1'b1, 30); phase(1'b0, 20);
    phase(1'b1, 30); phase(1'b0, 20);
    phase(1'b1, 3);
    check_meas("after_timeout", 3, 2);

    // period change at a rise
    repeat (3) begin
      phase(1'b1, 40); phase(1'b0, 10);
    end
    repeat (3) begin
      phase(1'b1, 10); phase(1'b0, 40);
    end
    phase(1'b1, 5);
    check_meas("stream_10_40", 1, 4);

    // edges on consecutive cycles
    phase(1'b0, 1); phase(1'b1, 1); phase(1'b0, 1); phase(1'b1, 1);
    phase(1'b0, 12); phase(1'b1, 1); phase(1'b0, 1); phase(1'b1, 25);

    // reset 15 cycles into a high phase of a 40/40 stream
    phase(1'b0, 40); phase(1'b1, 40); phase(1'b0, 40); phase(1'b1, 15);
    do_reset(1'b1, 3);
    phase(1'b1, 25);
    repeat (3) begin
      phase(1'b0, 40); phase(1'b1, 40);
    end
    check_meas("reset_40_40", 4, 4);

    // signal high at reset release
    do_reset(1'b1, 2);
    phase(1'b1, 20); phase(1'b0, 20);
    phase(1'b1, 30); phase(1'b0, 20);
    phase(1'b1, 5);

    // random phases, with an occasional near/over-saturation phase
    repeat (60) begin
      phase(1'b0, $urandom_range(1, 60));
      phase(1'b1, $urandom_range(1, 60));
      if ($urandom_range(0, 19) == 0) begin
        phase(1'b0, $urandom_range(2530, 2580));
      end
    end
    phase(1'b0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/square_wave_meter.md
SQUARE_WAVE_METER -- requirements
Module: square_wave_meter

Interface
REQ-001 Parameter BASE_CYCLES, default 10, clock cycles per base tick (100 ns at 100 MHz).
REQ-002 Parameter CNT_W, default 8, width of tick counters and measurement outputs.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 resets, 1 runs.
REQ-005 signal_in  input  1  square wave under measurement, synchronous to clk (e.g. square wave generator output).
REQ-006 on_ticks  output  CNT_W  high-phase duration of last complete period, in base ticks.
REQ-007 off_ticks  output  CNT_W  low-phase duration of last complete period, in base ticks.
REQ-008 valid  output  1  one-cycle pulse when on_ticks/off_ticks are updated.
REQ-009 timeout  output  1  level; current phase's tick counter is saturated.

Function
REQ-010 Block SHALL register signal_in into sig_d; edge cycle = cycle where primed=1 and signal_in != sig_d (rise: signal_in=1, fall: signal_in=0).
REQ-011 primed SHALL reset to 0 and become 1 after the first clock following reset release, so no edge is detected in the first cycle regardless of signal_in level.
REQ-012 Prescaler (0..BASE_CYCLES-1) SHALL load 1 on an edge cycle, else wrap to 0 after BASE_CYCLES-1, else increment.
REQ-013 Tick counter (CNT_W bits) SHALL load 0 on an edge cycle, else increment when prescaler==BASE_CYCLES-1, saturating at 2^CNT_W-1.
REQ-014 Net effect: a phase lasting H clock cycles SHALL measure floor(H/BASE_CYCLES) ticks (saturated).
REQ-015 FSM states: WAIT_EDGE (reset state), HIGH, LOW.
REQ-016 WAIT_EDGE: rise -> HIGH, fall -> LOW; no capture (partial phase discarded).
REQ-017 HIGH: fall -> LOW; if counter not saturated, capture counter into high_cap and set have_high=1, else have_high=0.
REQ-018 LOW: rise -> HIGH; if have_high=1 and counter not saturated, on_ticks<=high_cap, off_ticks<=counter, valid=1 next cycle; have_high cleared on every rise.
REQ-019 valid SHALL be high for exactly one cycle, the cycle after the rising edge cycle that completes the period; outputs hold until next update.
REQ-020 timeout SHALL be registered, high while tick counter==2^CNT_W-1, low from the cycle after the next edge cycle.
REQ-021 A saturated phase SHALL never contribute to a valid measurement (REQ-017/018).
REQ-022 Edges in consecutive cycles SHALL each be processed; a 1-cycle phase measures 0 ticks.

Reset
REQ-023 Reset assertion SHALL immediately force: on_ticks=0, off_ticks=0, valid=0, timeout=0, state=WAIT_EDGE, have_high=0, high_cap=0, prescaler=0, counter=0, sig_d=0, primed=0.
REQ-024 Reset mid-phase SHALL discard any partial measurement; next valid requires edge + full high + full low.

Verification
REQ-025 Reset release with signal_in=0 for 50 cycles, then repeat 30 high/20 low -> first valid at second rise with on_ticks=3, off_ticks=2; valid then every 50 cycles, outputs unchanged.
REQ-026 signal_in=1 at reset release -> no edge/valid in first cycle; first fall enters LOW without capture; first valid after a later full high+low.
REQ-027 Phase lengths H=5, 10, 19, 20 cycles (low fixed 10) -> on_ticks=0, 1, 1, 2 respectively; off_ticks=1.
REQ-028 CNT_W=8, low held 3000 cycles -> timeout rises ~2550 cycles after fall edge, falls the cycle after next rise; no valid at that rise; next full 30/20 period -> valid with 3/2.
REQ-029 Reset asserted 15 cycles into a high phase of a 40/40 stream -> all outputs 0 immediately; after release, no valid before one full period from first detected edge; then on_ticks=4, off_ticks=4.
REQ-030 Stream changes from 40/10 to 10/40 at a rise -> next valid reports 4/1 (old period), following valid reports 1/4.
